lsl_pipe: RTL and testbench
===========================

Name: lsl_pipe

Overview:
- Pipelined 32-bit logical left shifter for the SimpleRISC ALU's `lsl` instruction.
- Complements the combinational arithmetic right shifter:
  - same 5-level log-shifter decomposition (1, 2, 4, 8, 16);
  - shifts toward the MSB with zero fill;
  - one register stage per level, so it closes timing at full core clock.
- Valid/ready on input and output, global stall, and synchronous flush for squashing on a branch.

Parameters:
- WIDTH, 32, data width in bits. Must be a power of two.
- SHW, 5, shift-amount width. Equals log2(WIDTH). Pipeline depth equals SHW.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous squash of all in-flight operations.
- in_valid  input  1  d/sel/in_tag are valid this cycle.
- in_ready  output  1  pipeline can accept this cycle.
- d  input  WIDTH  operand to shift.
- sel  input  SHW  shift amount, 0..WIDTH-1.
- in_tag  input  4  destination-register tag, carried alongside the data.
- out_valid  output  1  x/out_tag/zero are valid.
- out_ready  input  1  consumer accepts the result this cycle.
- x  output  WIDTH  d << sel, zero-filled.
- out_tag  output  4  in_tag of the corresponding operation.
- zero  output  1  asserted when x == 0; valid together with out_valid.

Behaviour:
- One clock, clk; reset is synchronous and active-high (rst); every register updates only on the rising edge of clk.

Stages:
- Stage k, for k = 0..SHW-1, holds valid_k, data_k, sel_k and tag_k.
- Stage k output = sel[k] ? (input << 2^k) : input. Low 2^k bits are zero-filled; high bits are discarded.
- The sel bits still needed travel with the data, so each stage consumes only its own bit.
- Last stage registers drive x, out_tag and out_valid directly.
- zero is computed combinationally from the last-stage data register.

Handshake:
- advance = !out_valid || out_ready.
- in_ready = advance && !flush && !rst.
- Accept when in_valid && in_ready: the operation enters stage 0 at the next edge.
- When advance=1, every stage loads from its predecessor; valid_0 <= in_valid && in_ready.
- When advance=0, all stages hold. Global stall: bubbles are not compressed.
- Latency is exactly SHW (5) cycles from acceptance to out_valid with no stall. Throughput is 1 op/cycle.
- Results retire in acceptance order.
- x, out_tag and zero are stable while out_valid && !out_ready.

Reset:
- All valid bits 0, all data/sel/tag registers 0.
- out_valid=0, x=0, out_tag=0, zero=1.
- in_ready=0 during the reset cycle and 1 in the first cycle after.

Flush:
- At the next edge, all valid bits clear; data registers may keep stale values.
- in_ready=0 while flush is high, so a simultaneous in_valid is not accepted.
- An out_valid && out_ready handshake completing in the same cycle as flush still counts as delivered.
- rst has priority over flush; both have priority over advance.

Boundaries:
- sel=0: x=d.
- sel=31: x={d[0],31'b0}.
- Bits shifted past the MSB are lost; there is no carry/overflow output.
- Back-to-back acceptance every cycle while out_ready=1 produces one result per cycle, with no drops or duplicates.
- Stall of any length followed by release: results continue in order, nothing lost.
- Reset mid-operation: all in-flight results are discarded.

Test Plan:
1. Reset, then d=32'h0000_0001, sel=5'd31, tag=3, out_ready=1 -> exactly 5 cycles later out_valid=1, x=32'h8000_0000, out_tag=3, zero=0.
2. Stream d=32'hF0F0_1234 with sel=0,1,4,16,8 on consecutive cycles, out_ready=1 -> five consecutive out_valid cycles: x=F0F0_1234, E1E0_2468, 0F01_2340, 1234_0000, F012_3400.
3. d=32'h8000_0000, sel=1 -> x=0, zero=1. d=32'hFFFF_FFFF, sel=0 -> x=FFFF_FFFF, zero=0.
4. Fill the pipeline, then drop out_ready for 3 cycles -> in_ready=0 and x/out_tag held throughout. On release, the remaining results drain in order with none lost.
5. Three ops in flight, then flush asserted together with in_valid -> that input is not accepted, no out_valid within the next 6 cycles, and in_ready=1 the cycle after flush.
6. rst asserted mid-stream, then released -> out_valid=0, x=0, zero=1; earlier ops never appear; a new op with d=1, sel=4 yields x=32'h0000_0010 five cycles after acceptance.

Source files
------------

// File: rtl/lsl_if.sv
// Valid/ready bus for the pipelined logical left shifter.
// The producer/consumer side takes the master modport; the shifter takes the slave modport.
interface lsl_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5,
    parameter int unsigned TAGW  = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d;
    logic [SHW-1:0]   sel;
    logic [TAGW-1:0]  in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] x;
    logic [TAGW-1:0]  out_tag;
    logic             zero;

    modport master (
        output in_valid, d, sel, in_tag, out_ready,
        input  in_ready, out_valid, x, out_tag, zero
    );

    modport slave (
        input  in_valid, d, sel, in_tag, out_ready,
        output in_ready, out_valid, x, out_tag, zero
    );
endinterface

// File: rtl/lsl_pipe.sv
// Pipelined logical left shifter: one log-shifter level per register stage,
// global stall on back-pressure, synchronous flush and reset.
module lsl_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    lsl_if.slave   bus
);
    localparam int unsigned TAGW = 4;

    logic             r_valid [SHW];
    logic [WIDTH-1:0] r_data  [SHW];
    logic [SHW-1:0]   r_sel   [SHW];
    logic [TAGW-1:0]  r_tag   [SHW];

    logic             w_src_valid [SHW];
    logic [WIDTH-1:0] w_src_data  [SHW];
    logic [SHW-1:0]   w_src_sel   [SHW];
    logic [TAGW-1:0]  w_src_tag   [SHW];
    logic [WIDTH-1:0] w_nxt_data  [SHW];

    logic w_advance;
    logic w_accept;

    // Whole pipe moves together; bubbles are not squeezed out during a stall.
    assign w_advance    = !r_valid[SHW-1] || bus.out_ready;
    assign bus.in_ready = w_advance && !flush && !rst;
    assign w_accept     = bus.in_valid && bus.in_ready;

    generate
        for (genvar k = 0; k < SHW; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign w_src_valid[k] = w_accept;
                assign w_src_data[k]  = bus.d;
                assign w_src_sel[k]   = bus.sel;
                assign w_src_tag[k]   = bus.in_tag;
            end else begin : g_rest
                assign w_src_valid[k] = r_valid[k-1];
                assign w_src_data[k]  = r_data[k-1];
                assign w_src_sel[k]   = r_sel[k-1];
                assign w_src_tag[k]   = r_tag[k-1];
            end
            // Level k shifts by 2^k when its own sel bit is set.
            assign w_nxt_data[k] = w_src_sel[k][k] ? (w_src_data[k] << (2 ** k))
                                                   : w_src_data[k];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SHW; k++) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
                r_sel[k]   <= '0;
                r_tag[k]   <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < SHW; k++) begin
                r_valid[k] <= 1'b0;
            end
        end else if (w_advance) begin
            for (int k = 0; k < SHW; k++) begin
                r_valid[k] <= w_src_valid[k];
                r_data[k]  <= w_nxt_data[k];
                r_sel[k]   <= w_src_sel[k];
                r_tag[k]   <= w_src_tag[k];
            end
        end
    end

    assign bus.out_valid = r_valid[SHW-1];
    assign bus.x         = r_data[SHW-1];
    assign bus.out_tag   = r_tag[SHW-1];
    assign bus.zero      = (r_data[SHW-1] == '0);
endmodule

// File: tb/tb_lsl_pipe.sv
// Self-checking bench for lsl_pipe: queue-based reference model plus directed literal checks.
module tb_lsl_pipe;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned SHW   = 5;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    lsl_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    lsl_pipe #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [3:0]  tag;
        int          base;
    } exp_t;

    typedef struct {
        logic [31:0] x;
        logic [3:0]  tag;
        logic        zero;
        int          cyc;
    } out_t;

    exp_t mq[$];
    out_t olog[$];

    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc      = 0;
    int  adv_total = 0;
    int  acc_count = 0;
    int  last_acc_cyc = 0;
    bit  armed = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: in-order queue of pending results, each aged by pipeline advances.
    always @(negedge clk) begin
        if (armed) begin
            logic        exp_ov;
            logic        exp_adv;
            logic        exp_ir;
            logic [31:0] dv;
            exp_t        e;
            out_t        o;
            exp_ov  = (mq.size() > 0) && ((adv_total - mq[0].base) == int'(SHW));
            exp_adv = !exp_ov || bus.out_ready;
            exp_ir  = exp_adv && !flush && !rst;
            chk("in_ready", bus.in_ready, exp_ir);
            chk("out_valid", bus.out_valid, exp_ov);
            if (exp_ov) begin
                chk("x", bus.x, mq[0].x);
                chk("out_tag", bus.out_tag, mq[0].tag);
                chk("zero", bus.zero, mq[0].x == 32'h0);
            end
            if (bus.out_valid && bus.out_ready && !rst) begin
                o.x = bus.x; o.tag = bus.out_tag; o.zero = bus.zero; o.cyc = cyc;
                olog.push_back(o);
            end
            if (bus.in_valid && bus.in_ready) begin
                acc_count++;
                last_acc_cyc = cyc;
            end
            if (rst) begin
                mq.delete();
            end else if (flush) begin
                mq.delete();
            end else if (exp_adv) begin
                if (exp_ov) void'(mq.pop_front());
                adv_total++;
                if (bus.in_valid && exp_ir) begin
                    dv    = bus.d;
                    e.x   = dv << bus.sel;
                    e.tag = bus.in_tag;
                    e.base = adv_total - 1;
                    mq.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] dv, input logic [4:0] sv, input logic [3:0] tv);
        bus.in_valid = 1'b1;
        bus.d        = dv;
        bus.sel      = sv;
        bus.in_tag   = tv;
        step();
    endtask

    task automatic wait_log(input int n, input int budget);
        int k = 0;
        while (olog.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("wait_results", olog.size() >= n, 1'b1);
    endtask

    initial begin
        logic [31:0] t2_x [5];
        logic [4:0]  t2_s [5];
        logic [3:0]  t4_tags [7];
        logic [31:0] hold_x;
        logic [3:0]  hold_tag;
        int          acc0;
        int          ov_seen;

        t2_x    = '{32'hF0F0_1234, 32'hE1E0_2468, 32'h0F01_2340, 32'h1234_0000, 32'hF012_3400};
        t2_s    = '{5'd0, 5'd1, 5'd4, 5'd16, 5'd8};
        t4_tags = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9};

        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.d = '0; bus.sel = '0; bus.in_tag = '0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        armed = 1'b1;
        step();
        rst = 1'b0;

        // Reset state and first cycle after reset
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_x", bus.x, 32'h0);
        chk("rst_out_tag", bus.out_tag, 4'h0);
        chk("rst_zero", bus.zero, 1'b1);
        chk("rst_in_ready_after", bus.in_ready, 1'b1);
        step();

        // 1: single op, latency
        olog.delete();
        send(32'h0000_0001, 5'd31, 4'd3);
        bus.in_valid = 1'b0;
        wait_log(1, 20);
        if (olog.size() >= 1) begin
            chk("t1_x", olog[0].x, 32'h8000_0000);
            chk("t1_tag", olog[0].tag, 4'd3);
            chk("t1_zero", olog[0].zero, 1'b0);
            chk("t1_latency", olog[0].cyc - last_acc_cyc, 5);
        end

        // 2: stream of shifts
        olog.delete();
        for (int i = 0; i < 5; i++) send(32'hF0F0_1234, t2_s[i], 4'(i));
        bus.in_valid = 1'b0;
        wait_log(5, 20);
        if (olog.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("t2_x", olog[i].x, t2_x[i]);
                chk("t2_back_to_back", olog[i].cyc - olog[0].cyc, i);
            end
        end

        // 3: zero flag boundaries
        olog.delete();
        send(32'h8000_0000, 5'd1, 4'd1);
        send(32'hFFFF_FFFF, 5'd0, 4'd2);
        bus.in_valid = 1'b0;
        wait_log(2, 20);
        if (olog.size() >= 2) begin
            chk("t3_x0", olog[0].x, 32'h0);
            chk("t3_zero0", olog[0].zero, 1'b1);
            chk("t3_x1", olog[1].x, 32'hFFFF_FFFF);
            chk("t3_zero1", olog[1].zero, 1'b0);
        end
        repeat (3) step();

        // 4: fill, stall three cycles, release
        olog.delete();
        acc0 = acc_count;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid  = 1'b1;
            bus.d         = $urandom;
            bus.sel       = 5'($urandom_range(0, 31));
            bus.in_tag    = 4'(i);
            bus.out_ready = !(i >= 6 && i < 9);
            @(negedge clk);
            if (i == 6) begin
                hold_x   = bus.x;
                hold_tag = bus.out_tag;
            end
            if (i > 6 && i < 9) begin
                chk("t4_hold_x", bus.x, hold_x);
                chk("t4_hold_tag", bus.out_tag, hold_tag);
            end
            if (i >= 6 && i < 9) chk("t4_stall_in_ready", bus.in_ready, 1'b0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) step();
        chk("t4_count", olog.size(), acc_count - acc0);
        if (olog.size() == 7) begin
            for (int i = 0; i < 7; i++) chk("t4_order", olog[i].tag, t4_tags[i]);
        end

        // 5: flush with three in flight
        olog.delete();
        for (int i = 0; i < 3; i++) send(32'h1234_5678, 5'(i), 4'(i));
        bus.in_valid = 1'b1;
        flush = 1'b1;
        acc0 = acc_count;
        @(negedge clk);
        chk("t5_flush_in_ready", bus.in_ready, 1'b0);
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t5_in_ready_after", bus.in_ready, 1'b1);
        step();
        ov_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) ov_seen++;
            step();
        end
        chk("t5_no_out_valid", ov_seen, 0);
        chk("t5_not_accepted", acc_count, acc0);

        // 6: reset mid-stream
        for (int i = 0; i < 3; i++) send(32'hDEAD_BEEF, 5'(i), 4'(i + 1));
        bus.in_valid = 1'b0;
        rst = 1'b1;
        olog.delete();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_out_valid", bus.out_valid, 1'b0);
        chk("t6_x", bus.x, 32'h0);
        chk("t6_zero", bus.zero, 1'b1);
        step();
        send(32'h0000_0001, 5'd4, 4'd7);
        bus.in_valid = 1'b0;
        wait_log(1, 20);
        repeat (3) step();
        chk("t6_count", olog.size(), 1);
        if (olog.size() >= 1) begin
            chk("t6_x_new", olog[0].x, 32'h0000_0010);
            chk("t6_tag_new", olog[0].tag, 4'd7);
            chk("t6_latency", olog[0].cyc - last_acc_cyc, 5);
        end

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.d         = $urandom;
            bus.sel       = 5'($urandom_range(0, 31));
            bus.in_tag    = 4'($urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 49) == 0);
            rst           = ($urandom_range(0, 199) == 0);
            step();
        end
        bus.in_valid = 1'b0; flush = 1'b0; rst = 1'b0; bus.out_ready = 1'b1;
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
